// File: rtl/img_ctrl_pkg.sv
// Shared encodings for the image-filter control sequencer: window-buffer ops,
// memory/address modes and the sequencer state set.
package img_ctrl_pkg;

    localparam logic [2:0] WB_NOP  = 3'd0;
    localparam logic [2:0] WB_S1   = 3'd1;
    localparam logic [2:0] WB_S2   = 3'd2;
    localparam logic [2:0] WB_SD3  = 3'd3;
    localparam logic [2:0] WB_SD4  = 3'd4;
    localparam logic [2:0] WB_SHFT = 3'd5;

    localparam logic SRAM_READ      = 1'b1;
    localparam logic SRAM_WRITE     = 1'b0;
    localparam logic ADDR_ROWCACHE  = 1'b1;
    localparam logic ADDR_OUTPUTARR = 1'b0;
    localparam logic SDRAM_READ     = 1'b1;
    localparam logic SDRAM_WRITE    = 1'b0;

    typedef enum logic [4:0] {
        ST_IDLE, ST_R0_RD, ST_R0_WAIT, ST_R0_WR, ST_R0_INC, ST_ROW_NEXT,
        ST_C0_SRD, ST_C0_SWAIT, ST_C0_WB1, ST_C0_DRD, ST_C0_DWAIT, ST_C0_WR, ST_C0_INC,
        ST_PX_SRD, ST_PX_SWAIT, ST_PX_WB2, ST_PX_DRD, ST_PX_DWAIT, ST_PX_CWR,
        ST_PX_OWR, ST_PX_OUPD, ST_PX_INC, ST_PX_SHFT,
        ST_FL_RD, ST_FL_SWAIT, ST_FL_WR, ST_FL_WWAIT, ST_FL_INC,
        ST_DONE, ST_ERR
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == ST_R0_WAIT) || (s == ST_C0_SWAIT) || (s == ST_C0_DWAIT) ||
               (s == ST_PX_SWAIT) || (s == ST_PX_DWAIT) || (s == ST_FL_SWAIT) ||
               (s == ST_FL_WWAIT);
    endfunction

endpackage

// File: rtl/img_ctrl_seq_timer.sv
// Request watchdog shared by every wait state: counts cycles spent waiting and
// flags the last permitted cycle.
module req_timeout_timer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            count_reg <= '0;
        end else if (tick && !expired) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    // High during the TIMEOUT-th cycle of a wait; a response in that cycle still wins.
    assign expired = (count_reg == LAST);

endmodule

// File: rtl/img_ctrl_seq.sv
// Sequencer for a 2x2-window filter over a runtime-sized image: row caching,
// window-buffer feeding, output array fill and final flush back to SDRAM.
module img_ctrl_seq
    import img_ctrl_pkg::*;
#(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_flag,
    input  logic [CNT_W-1:0] img_w,
    input  logic [CNT_W-1:0] img_h,
    input  logic             dataRead_sram,
    input  logic             dataRead_sdram,
    input  logic             dataWritten_sdram,
    output logic             enable_i,
    output logic             enable_j,
    output logic             enable_i_wr,
    output logic             enable_addr_calc_sram,
    output logic             enable_addr_calc_sdram,
    output logic             enable_WB,
    output logic [2:0]       mode_WB,
    output logic             enable_sram,
    output logic             mode_sram,
    output logic             read_en_sdram,
    output logic             write_en_sdram,
    output logic             mode_addr_calc_sram,
    output logic             mode_addr_calc_sdram,
    output logic [CNT_W-1:0] col_idx,
    output logic [CNT_W-1:0] row_idx,
    output logic             busy,
    output logic             finish_flag,
    output logic             error_flag
);

    localparam int KW = 2 * CNT_W;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] w_reg, h_reg, i_reg, j_reg;
    logic [KW-1:0]    k_reg;
    logic [KW-1:0]    flush_last;
    logic             dims_ok;
    logic             expired;

    assign dims_ok    = (img_w >= CNT_W'(2)) && (img_h >= CNT_W'(2));
    assign flush_last = (KW'(w_reg) - KW'(1)) * (KW'(h_reg) - KW'(1)) - KW'(1);
    assign col_idx    = i_reg;
    assign row_idx    = j_reg;

    req_timeout_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (!is_wait(state_reg)),
        .tick    (is_wait(state_reg)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            w_reg <= '0;
            h_reg <= '0;
            i_reg <= '0;
            j_reg <= '0;
            k_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ERR: begin
                    if (start_flag) begin
                        w_reg <= img_w;
                        h_reg <= img_h;
                        if (dims_ok) begin
                            i_reg <= '0;
                            j_reg <= '0;
                            k_reg <= '0;
                        end
                    end
                end
                ST_R0_INC, ST_C0_INC, ST_PX_INC: i_reg <= i_reg + CNT_W'(1);
                ST_ROW_NEXT: begin
                    i_reg <= '0;
                    j_reg <= j_reg + CNT_W'(1);
                end
                ST_FL_INC: k_reg <= k_reg + KW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next             = state_reg;
        enable_i               = 1'b0;
        enable_j               = 1'b0;
        enable_i_wr            = 1'b0;
        enable_addr_calc_sram  = 1'b0;
        enable_addr_calc_sdram = 1'b0;
        enable_WB              = 1'b0;
        mode_WB                = WB_NOP;
        enable_sram            = 1'b0;
        mode_sram              = SRAM_WRITE;
        read_en_sdram          = 1'b0;
        write_en_sdram         = 1'b0;
        mode_addr_calc_sram    = ADDR_ROWCACHE;
        mode_addr_calc_sdram   = SDRAM_READ;
        busy                   = 1'b1;
        finish_flag            = 1'b0;
        error_flag             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_flag) state_next = dims_ok ? ST_R0_RD : ST_ERR;
            end
            ST_ERR: begin
                busy       = 1'b0;
                error_flag = 1'b1;
                if (start_flag) state_next = dims_ok ? ST_R0_RD : ST_ERR;
            end
            ST_R0_RD: begin
                read_en_sdram = 1'b1;
                state_next    = ST_R0_WAIT;
            end
            ST_R0_WAIT: begin
                if (dataRead_sdram) state_next = ST_R0_WR;
                else if (expired)   state_next = ST_ERR;
            end
            ST_R0_WR: begin
                enable_sram = 1'b1;
                state_next  = ST_R0_INC;
            end
            ST_R0_INC: begin
                enable_i               = 1'b1;
                enable_addr_calc_sram  = 1'b1;
                enable_addr_calc_sdram = 1'b1;
                state_next = (i_reg == w_reg - CNT_W'(1)) ? ST_ROW_NEXT : ST_R0_RD;
            end
            ST_ROW_NEXT: begin
                enable_j   = 1'b1;
                state_next = (j_reg + CNT_W'(1) == h_reg) ? ST_FL_RD : ST_C0_SRD;
            end
            ST_C0_SRD: begin
                enable_sram = 1'b1;
                mode_sram   = SRAM_READ;
                state_next  = ST_C0_SWAIT;
            end
            ST_C0_SWAIT: begin
                if (dataRead_sram) state_next = ST_C0_WB1;
                else if (expired)  state_next = ST_ERR;
            end
            ST_C0_WB1: begin
                enable_WB  = 1'b1;
                mode_WB    = WB_S1;
                state_next = ST_C0_DRD;
            end
            ST_C0_DRD: begin
                read_en_sdram = 1'b1;
                state_next    = ST_C0_DWAIT;
            end
            ST_C0_DWAIT: begin
                if (dataRead_sdram) state_next = ST_C0_WR;
                else if (expired)   state_next = ST_ERR;
            end
            ST_C0_WR: begin
                enable_WB   = 1'b1;
                mode_WB     = WB_SD3;
                enable_sram = 1'b1;
                state_next  = ST_C0_INC;
            end
            ST_C0_INC: begin
                enable_i               = 1'b1;
                enable_addr_calc_sram  = 1'b1;
                enable_addr_calc_sdram = 1'b1;
                state_next             = ST_PX_SRD;
            end
            ST_PX_SRD: begin
                enable_sram = 1'b1;
                mode_sram   = SRAM_READ;
                state_next  = ST_PX_SWAIT;
            end
            ST_PX_SWAIT: begin
                if (dataRead_sram) state_next = ST_PX_WB2;
                else if (expired)  state_next = ST_ERR;
            end
            ST_PX_WB2: begin
                enable_WB  = 1'b1;
                mode_WB    = WB_S2;
                state_next = ST_PX_DRD;
            end
            ST_PX_DRD: begin
                read_en_sdram = 1'b1;
                state_next    = ST_PX_DWAIT;
            end
            ST_PX_DWAIT: begin
                if (dataRead_sdram) state_next = ST_PX_CWR;
                else if (expired)   state_next = ST_ERR;
            end
            ST_PX_CWR: begin
                enable_WB   = 1'b1;
                mode_WB     = WB_SD4;
                enable_sram = 1'b1;
                state_next  = ST_PX_OWR;
            end
            ST_PX_OWR: begin
                enable_sram         = 1'b1;
                mode_addr_calc_sram = ADDR_OUTPUTARR;
                state_next          = ST_PX_OUPD;
            end
            ST_PX_OUPD: begin
                enable_addr_calc_sram  = 1'b1;
                mode_addr_calc_sram    = ADDR_OUTPUTARR;
                enable_addr_calc_sdram = 1'b1;
                state_next             = ST_PX_INC;
            end
            ST_PX_INC: begin
                enable_i              = 1'b1;
                enable_addr_calc_sram = 1'b1;
                state_next            = ST_PX_SHFT;
            end
            ST_PX_SHFT: begin
                enable_WB  = 1'b1;
                mode_WB    = WB_SHFT;
                // i was already advanced in PX_INC, so W here means the row is complete
                state_next = (i_reg == w_reg) ? ST_ROW_NEXT : ST_PX_SRD;
            end
            ST_FL_RD: begin
                enable_sram         = 1'b1;
                mode_sram           = SRAM_READ;
                mode_addr_calc_sram = ADDR_OUTPUTARR;
                state_next          = ST_FL_SWAIT;
            end
            ST_FL_SWAIT: begin
                if (dataRead_sram) state_next = ST_FL_WR;
                else if (expired)  state_next = ST_ERR;
            end
            ST_FL_WR: begin
                write_en_sdram       = 1'b1;
                mode_addr_calc_sdram = SDRAM_WRITE;
                state_next           = ST_FL_WWAIT;
            end
            ST_FL_WWAIT: begin
                if (dataWritten_sdram) state_next = ST_FL_INC;
                else if (expired)      state_next = ST_ERR;
            end
            ST_FL_INC: begin
                enable_i_wr            = 1'b1;
                enable_addr_calc_sram  = 1'b1;
                mode_addr_calc_sram    = ADDR_OUTPUTARR;
                enable_addr_calc_sdram = 1'b1;
                mode_addr_calc_sdram   = SDRAM_WRITE;
                state_next = (k_reg == flush_last) ? ST_DONE : ST_FL_RD;
            end
            ST_DONE: begin
                finish_flag = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_img_ctrl_seq.sv
// Randomised scoreboard bench: a pixel-loop reference model predicts every strobe
// cycle, a monitor compares them as the sequencer emits them.
module tb_img_ctrl_seq;

    localparam int CW = 12;

    typedef logic [39:0] ev_t;
    typedef enum int {
        K_R0RD, K_R0WR, K_INC2, K_ROWN, K_SRD, K_WB1, K_C0DRD, K_C0WR, K_WB2,
        K_PXDRD, K_CWR, K_OWR, K_OUPD, K_PXINC, K_SHFT, K_FLRD, K_FLWR, K_FLINC, K_DONE
    } kind_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start_flag = 1'b0;
    logic [CW-1:0] img_w = '0;
    logic [CW-1:0] img_h = '0;
    logic          dataRead_sram = 1'b0;
    logic          dataRead_sdram = 1'b0;
    logic          dataWritten_sdram = 1'b0;
    logic          enable_i, enable_j, enable_i_wr;
    logic          enable_addr_calc_sram, enable_addr_calc_sdram;
    logic          enable_WB, enable_sram, mode_sram;
    logic [2:0]    mode_WB;
    logic          read_en_sdram, write_en_sdram;
    logic          mode_addr_calc_sram, mode_addr_calc_sdram;
    logic [CW-1:0] col_idx, row_idx;
    logic          busy, finish_flag, error_flag;

    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    int   wb_seq[$];
    int   ev_cnt = 0, owr_cnt = 0, wr_cnt = 0, fin_cnt = 0, max_owr_row = 0;
    int   fixed_dly = -1;
    int   drop_at = 0;
    int   sd_req_cnt = 0;
    kind_t lim_kind = K_DONE;
    int   lim_cnt = 0, lim_hits = 0;
    bit   lim_stop = 0;

    img_ctrl_seq #(.CNT_W(CW), .TIMEOUT(4), .TO_W(8)) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .start_flag             (start_flag),
        .img_w                  (img_w),
        .img_h                  (img_h),
        .dataRead_sram          (dataRead_sram),
        .dataRead_sdram         (dataRead_sdram),
        .dataWritten_sdram      (dataWritten_sdram),
        .enable_i               (enable_i),
        .enable_j               (enable_j),
        .enable_i_wr            (enable_i_wr),
        .enable_addr_calc_sram  (enable_addr_calc_sram),
        .enable_addr_calc_sdram (enable_addr_calc_sdram),
        .enable_WB              (enable_WB),
        .mode_WB                (mode_WB),
        .enable_sram            (enable_sram),
        .mode_sram              (mode_sram),
        .read_en_sdram          (read_en_sdram),
        .write_en_sdram         (write_en_sdram),
        .mode_addr_calc_sram    (mode_addr_calc_sram),
        .mode_addr_calc_sdram   (mode_addr_calc_sdram),
        .col_idx                (col_idx),
        .row_idx                (row_idx),
        .busy                   (busy),
        .finish_flag            (finish_flag),
        .error_flag             (error_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    // Expected strobe cycle: {en_i,en_j,en_i_wr,en_as,en_ad,en_wb,mode_wb,en_sram,
    // mode_sram,rd,wr,mode_as,mode_ad,finish,col,row}; idle modes are WRITE/ROWCACHE/READ.
    function automatic ev_t mk(input kind_t k, input int col, input int row);
        logic ei = 0, ej = 0, eiw = 0, eas = 0, ead = 0, ewb = 0, esr = 0;
        logic msr = 0, rd = 0, wr = 0, mas = 1, mad = 1, fin = 0;
        logic [2:0] mwb = 3'd0;
        case (k)
            K_R0RD, K_C0DRD, K_PXDRD: rd = 1;
            K_R0WR:  esr = 1;
            K_INC2:  begin ei = 1; eas = 1; ead = 1; end
            K_ROWN:  ej = 1;
            K_SRD:   begin esr = 1; msr = 1; end
            K_WB1:   begin ewb = 1; mwb = 3'd1; end
            K_C0WR:  begin ewb = 1; mwb = 3'd3; esr = 1; end
            K_WB2:   begin ewb = 1; mwb = 3'd2; end
            K_CWR:   begin ewb = 1; mwb = 3'd4; esr = 1; end
            K_OWR:   begin esr = 1; mas = 0; end
            K_OUPD:  begin eas = 1; mas = 0; ead = 1; end
            K_PXINC: begin ei = 1; eas = 1; end
            K_SHFT:  begin ewb = 1; mwb = 3'd5; end
            K_FLRD:  begin esr = 1; msr = 1; mas = 0; end
            K_FLWR:  begin wr = 1; mad = 0; end
            K_FLINC: begin eiw = 1; eas = 1; ead = 1; mas = 0; mad = 0; end
            K_DONE:  fin = 1;
            default: ;
        endcase
        return {ei, ej, eiw, eas, ead, ewb, mwb, esr, msr, rd, wr, mas, mad, fin,
                CW'(col), CW'(row)};
    endfunction

    task automatic push(input kind_t k, input int col, input int row);
        if (!lim_stop) begin
            exp_q.push_back(mk(k, col, row));
            if (lim_cnt > 0 && k == lim_kind) begin
                lim_hits++;
                if (lim_hits == lim_cnt) lim_stop = 1;
            end
        end
    endtask

    // Whole-image expectation, optionally cut after the lc-th occurrence of kind lk.
    task automatic gen(input int w, input int h, input kind_t lk, input int lc);
        lim_kind = lk; lim_cnt = lc; lim_hits = 0; lim_stop = 0;
        for (int p = 0; p < w; p++) begin
            push(K_R0RD, p, 0); push(K_R0WR, p, 0); push(K_INC2, p, 0);
        end
        for (int j = 1; j < h; j++) begin
            push(K_ROWN, w, j - 1);
            push(K_SRD, 0, j); push(K_WB1, 0, j); push(K_C0DRD, 0, j);
            push(K_C0WR, 0, j); push(K_INC2, 0, j);
            for (int i = 1; i < w; i++) begin
                push(K_SRD, i, j); push(K_WB2, i, j); push(K_PXDRD, i, j); push(K_CWR, i, j);
                push(K_OWR, i, j); push(K_OUPD, i, j); push(K_PXINC, i, j); push(K_SHFT, i + 1, j);
            end
        end
        push(K_ROWN, w, h - 1);
        for (int k = 0; k < (w - 1) * (h - 1); k++) begin
            push(K_FLRD, 0, h); push(K_FLWR, 0, h); push(K_FLINC, 0, h);
        end
        push(K_DONE, 0, h);
    endtask

    initial begin : sdram_rd_resp
        int d;
        forever begin
            @(negedge clk);
            if (read_en_sdram) begin
                sd_req_cnt++;
                if (sd_req_cnt != drop_at) begin
                    d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                    repeat (d + 1) @(posedge clk);
                    #1 dataRead_sdram = 1'b1;
                    @(posedge clk);
                    #1 dataRead_sdram = 1'b0;
                end
            end
        end
    end

    initial begin : sram_rd_resp
        int d;
        forever begin
            @(negedge clk);
            if (enable_sram && mode_sram) begin
                d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                repeat (d + 1) @(posedge clk);
                #1 dataRead_sram = 1'b1;
                @(posedge clk);
                #1 dataRead_sram = 1'b0;
            end
        end
    end

    initial begin : sdram_wr_resp
        int d;
        forever begin
            @(negedge clk);
            if (write_en_sdram) begin
                d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                repeat (d + 1) @(posedge clk);
                #1 dataWritten_sdram = 1'b1;
                @(posedge clk);
                #1 dataWritten_sdram = 1'b0;
            end
        end
    end

    initial begin : monitor
        ev_t got, e;
        forever begin
            @(negedge clk);
            got = {enable_i, enable_j, enable_i_wr, enable_addr_calc_sram, enable_addr_calc_sdram,
                   enable_WB, mode_WB, enable_sram, mode_sram, read_en_sdram, write_en_sdram,
                   mode_addr_calc_sram, mode_addr_calc_sdram, finish_flag, col_idx, row_idx};
            if (enable_i | enable_j | enable_i_wr | enable_addr_calc_sram | enable_addr_calc_sdram |
                enable_WB | enable_sram | read_en_sdram | write_en_sdram | finish_flag) begin
                ev_cnt++;
                if (enable_sram && !mode_sram && !mode_addr_calc_sram) begin
                    owr_cnt++;
                    if (int'(row_idx) > max_owr_row) max_owr_row = int'(row_idx);
                end
                if (write_en_sdram) wr_cnt++;
                if (finish_flag) fin_cnt++;
                if (enable_WB) wb_seq.push_back(int'(mode_WB));
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_unexpected got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL scoreboard ev=%0d got=%h required=%h", ev_cnt, got, e);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        exp_q.delete(); wb_seq.delete();
        ev_cnt = 0; owr_cnt = 0; wr_cnt = 0; fin_cnt = 0; max_owr_row = 0; sd_req_cnt = 0;
    endtask

    task automatic start_run(input int w, input int h);
        @(negedge clk);
        img_w = CW'(w); img_h = CW'(h); start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (!finish_flag && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_done_seen"}, finish_flag, 1);
    endtask

    task automatic end_run(input string nm, input int w, input int h);
        repeat (6) @(negedge clk);
        chk({nm, "_finish_once"}, fin_cnt, 1);
        chk({nm, "_out_writes"}, owr_cnt, (w - 1) * (h - 1));
        chk({nm, "_sdram_writes"}, wr_cnt, (w - 1) * (h - 1));
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        $display("run %s w=%0d h=%0d events=%0d", nm, w, h, ev_cnt);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_error"}, error_flag, 0);
        chk({nm, "_strobes"}, {enable_i, enable_j, enable_i_wr, enable_addr_calc_sram,
            enable_addr_calc_sdram, enable_WB, enable_sram, read_en_sdram, write_en_sdram,
            finish_flag}, 0);
        chk({nm, "_mode_wb"}, mode_WB, 0);
        chk({nm, "_mode_sram"}, mode_sram, 0);
        chk({nm, "_mode_as"}, mode_addr_calc_sram, 1);
        chk({nm, "_mode_ad"}, mode_addr_calc_sdram, 1);
        chk({nm, "_col"}, col_idx, 0);
        chk({nm, "_row"}, row_idx, 0);
    endtask

    initial begin : guard
        #900000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        int exp_wb[5] = '{1, 3, 2, 4, 5};
        int n, c, waits, w, h;

        repeat (3) @(negedge clk);
        chk_reset("por");
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // 2x2 with fixed one-cycle-late responses
        clear_stats(); fixed_dly = 1;
        gen(2, 2, K_DONE, 0);
        start_run(2, 2);
        wait_done("w2h2");
        end_run("w2h2", 2, 2);
        chk("w2h2_wb_count", wb_seq.size(), 5);
        for (int i = 0; i < 5 && i < wb_seq.size(); i++) chk("w2h2_wb_mode", wb_seq[i], exp_wb[i]);

        // 3x3 with a start pulse during row 1 that must be ignored
        clear_stats(); fixed_dly = -1;
        gen(3, 3, K_DONE, 0);
        start_run(3, 3);
        c = 0;
        while (row_idx != CW'(1) && c < 2000) begin @(negedge clk); c++; end
        chk("w3h3_row1_reached", row_idx, 1);
        img_w = CW'(7); img_h = CW'(9); start_flag = 1'b1;
        @(negedge clk);
        start_flag = 1'b0;
        wait_done("w3h3");
        end_run("w3h3", 3, 3);
        chk("w3h3_max_row", max_owr_row, 2);

        // bad dimensions go straight to ERR with no memory traffic
        clear_stats();
        start_run(1, 5);
        chk("w1h5_error", error_flag, 1);
        chk("w1h5_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("w1h5_no_strobes", ev_cnt, 0);
        chk("w1h5_error_sticky", error_flag, 1);
        $display("run w1h5 error_flag=%0d events=%0d", error_flag, ev_cnt);

        // withheld SDRAM read in PX_DWAIT: 4th SDRAM read of a 2x2 image
        clear_stats(); drop_at = 4;
        gen(2, 2, K_PXDRD, 1);
        start_run(2, 2);
        n = 0; c = 0;
        while (c < 2000) begin
            if (read_en_sdram) n++;
            if (n == 4) break;
            @(negedge clk);
            c++;
        end
        chk("timeout_req_seen", n, 4);
        waits = 0;
        @(negedge clk);
        while (!error_flag && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        chk("timeout_wait_cycles", waits, 4);
        chk("timeout_error", error_flag, 1);
        chk("timeout_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("timeout_queue_empty", exp_q.size(), 0);
        $display("run timeout waits=%0d error_flag=%0d", waits, error_flag);
        drop_at = 0;

        // restart out of ERR
        clear_stats();
        gen(2, 2, K_DONE, 0);
        start_run(2, 2);
        chk("restart_error_cleared", error_flag, 0);
        chk("restart_busy", busy, 1);
        wait_done("restart");
        end_run("restart", 2, 2);

        // reset after the third flush increment
        clear_stats();
        gen(3, 3, K_FLINC, 3);
        start_run(3, 3);
        n = 0; c = 0;
        while (c < 5000) begin
            if (enable_i_wr) n++;
            if (n == 3) break;
            @(negedge clk);
            c++;
        end
        chk("flush_inc_reached", n, 3);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("rst_mid_flush");
        repeat (3) @(negedge clk);
        chk("rst_mid_flush_queue_empty", exp_q.size(), 0);
        $display("run rst_mid_flush events=%0d", ev_cnt);
        n_rst = 1'b1;
        repeat (8) @(negedge clk);

        // random image sizes and response delays
        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(2, 5));
            h = int'($urandom_range(2, 5));
            clear_stats();
            gen(w, h, K_DONE, 0);
            start_run(w, h);
            wait_done("rand");
            end_run("rand", w, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
